// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and press-detect for the calculator push buttons.
// Optional auto-repeat of held digit keys is built when AUTO_REPEAT_EN is defined.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   btn_raw    in   raw asynchronous button levels, 1 = pressed
//   btn_level  out  debounced button levels
//   btn_pulse  out  one-cycle strobe per accepted press (and per repeat)
//   key_code   out  1..N_BTN of last press/repeat, 0 = none since reset
//   key_valid  out  one-cycle strobe when key_code updates
//   any_held   out  OR of btn_level
module button_conditioner #(
  parameter int N_BTN = 9,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE = 15000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK =
    N_BTN'(9'b000001111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             any_held
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] lvl_nxt;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pulse_nxt;
  logic [3:0]       code_nxt;

  always_comb begin
    lvl_nxt = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      if (s2[i] != btn_level[i] && cnt[i] == DB_LAST)
        lvl_nxt[i] = s2[i];
    end
    press = lvl_nxt & ~btn_level;
  end

  // Walk downward so the lowest pulsing index wins.
  always_comb begin
    code_nxt = key_code;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_pulse[i])
        code_nxt = 4'(i + 1);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  // The counter is cleared the cycle after each strobe,
  // so two cycles of the interval have already elapsed
  // when it starts counting again.
  localparam logic [RW-1:0] LIM_D = RW'(REPEAT_DELAY - 2);
  localparam logic [RW-1:0] LIM_R = RW'(REPEAT_RATE - 2);

  logic [RW-1:0]    rcnt;
  logic [RW-1:0]    lim;
  logic             rep_phase;
  logic             hold_ok;
  logic             fire;
  logic [N_BTN-1:0] fire_vec;

  always_comb begin
    hold_ok = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (key_code == 4'(i + 1) && btn_level[i] &&
          REPEAT_MASK[i])
        hold_ok = 1'b1;
    end
    lim  = rep_phase ? LIM_R : LIM_D;
    fire = hold_ok && (btn_pulse == '0) && (rcnt == lim);
    fire_vec = '0;
    for (int i = 0; i < N_BTN; i++)
      fire_vec[i] = fire && (key_code == 4'(i + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else begin
      if (btn_pulse != '0 || !hold_ok)
        rcnt <= '0;
      else
        rcnt <= rcnt + 1'b1;
      if (press != '0)
        rep_phase <= 1'b0;
      else if (fire)
        rep_phase <= 1'b1;
    end
  end

  assign pulse_nxt = press | fire_vec;
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_MASK, REPEAT_DELAY[0],
                        REPEAT_RATE[0]};
  assign pulse_nxt = press;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      any_held  <= 1'b0;
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= '0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      btn_level <= lvl_nxt;
      btn_pulse <= pulse_nxt;
      key_code  <= code_nxt;
      key_valid <= |btn_pulse;
      any_held  <= |lvl_nxt;
      // A sample equal to the level (a bounce) restarts the count.
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_level[i] || cnt[i] == DB_LAST)
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven bench for button_conditioner.
// Rows give inputs before an edge and expected outputs after it.
module tb_button_conditioner;

  localparam logic [8:0] RMASK = 9'b000001111;
  localparam int HOLD = 38;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] btn_raw = '0;
  logic [8:0] btn_level;
  logic [8:0] btn_pulse;
  logic [3:0] key_code;
  logic       key_valid;
  logic       any_held;

  button_conditioner #(
    .N_BTN(9),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5),
    .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .key_code(key_code),
    .key_valid(key_valid),
    .any_held(any_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [8:0] raw;
    logic [8:0] lvl;
    logic [8:0] pls;
    logic [3:0] code;
    bit         vld;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];
  int   passed = 0;
  int   total = 0;

  function automatic void add(int n, bit r, logic [8:0] raw,
                              logic [8:0] lvl, logic [8:0] pls,
                              logic [3:0] code, bit vld);
    vec_t v;
    v.rst = r;
    v.raw = raw;
    v.lvl = lvl;
    v.pls = pls;
    v.code = code;
    v.vld = vld;
    for (int i = 0; i < n; i++)
      tv.push_back(v);
  endfunction

  // Press strobe at c=5; repeats at 15, 20, 25 ... while held.
  function automatic bit fired(int c, bit rep);
    return c == 5 ||
      (rep && c >= 15 && c < HOLD + 5 && (c - 15) % 5 == 0);
  endfunction

  function automatic void hold_seq(int idx, logic [3:0] prev);
    logic [8:0] m;
    bit rep;
    m = 9'd1 << idx;
`ifdef AUTO_REPEAT_EN
    rep = RMASK[idx];
`else
    rep = 1'b0;
`endif
    for (int c = 0; c < HOLD + 7; c++)
      add(1, 1'b0,
          (c < HOLD) ? m : 9'd0,
          (c >= 5 && c < HOLD + 5) ? m : 9'd0,
          fired(c, rep) ? m : 9'd0,
          (c >= 6) ? 4'(idx + 1) : prev,
          fired(c - 1, rep));
  endfunction

  task automatic check(input int row, input vec_t e);
    total++;
    if (btn_level === e.lvl && btn_pulse === e.pls &&
        key_code === e.code && key_valid === e.vld &&
        any_held === (|e.lvl))
      passed++;
    else
      $display("FAIL row %0d: got lvl=%h pls=%h code=%0d vld=%b held=%b want lvl=%h pls=%h code=%0d vld=%b held=%b",
               row, btn_level, btn_pulse, key_code, key_valid,
               any_held, e.lvl, e.pls, e.code, e.vld, |e.lvl);
  endtask

  initial begin
    vec_t e;
    // reset with all buttons held, then release
    add(3, 1, 9'h1FF, 9'h000, 9'h000, 4'd0, 0);
    add(5, 0, 9'h1FF, 9'h000, 9'h000, 4'd0, 0);
    add(1, 0, 9'h1FF, 9'h1FF, 9'h1FF, 4'd0, 0);
    add(1, 0, 9'h1FF, 9'h1FF, 9'h000, 4'd1, 1);
    add(5, 0, 9'h000, 9'h1FF, 9'h000, 4'd1, 0);
    add(2, 0, 9'h000, 9'h000, 9'h000, 4'd1, 0);
    // clean press of B3
    add(5, 0, 9'h004, 9'h000, 9'h000, 4'd1, 0);
    add(1, 0, 9'h004, 9'h004, 9'h004, 4'd1, 0);
    add(1, 0, 9'h004, 9'h004, 9'h000, 4'd3, 1);
    add(5, 0, 9'h000, 9'h004, 9'h000, 4'd3, 0);
    add(2, 0, 9'h000, 9'h000, 9'h000, 4'd3, 0);
    // bounce on B1: 1,1,1,0 then stable
    add(3, 0, 9'h001, 9'h000, 9'h000, 4'd3, 0);
    add(1, 0, 9'h000, 9'h000, 9'h000, 4'd3, 0);
    add(5, 0, 9'h001, 9'h000, 9'h000, 4'd3, 0);
    add(1, 0, 9'h001, 9'h001, 9'h001, 4'd3, 0);
    add(1, 0, 9'h001, 9'h001, 9'h000, 4'd1, 1);
    add(5, 0, 9'h000, 9'h001, 9'h000, 4'd1, 0);
    add(2, 0, 9'h000, 9'h000, 9'h000, 4'd1, 0);
    // simultaneous B5 and B7
    add(5, 0, 9'h050, 9'h000, 9'h000, 4'd1, 0);
    add(1, 0, 9'h050, 9'h050, 9'h050, 4'd1, 0);
    add(1, 0, 9'h050, 9'h050, 9'h000, 4'd5, 1);
    add(5, 0, 9'h000, 9'h050, 9'h000, 4'd5, 0);
    add(2, 0, 9'h000, 9'h000, 9'h000, 4'd5, 0);
    // reset in the middle of debouncing B9
    add(3, 0, 9'h100, 9'h000, 9'h000, 4'd5, 0);
    add(1, 1, 9'h100, 9'h000, 9'h000, 4'd0, 0);
    add(5, 0, 9'h100, 9'h000, 9'h000, 4'd0, 0);
    add(1, 0, 9'h100, 9'h100, 9'h100, 4'd0, 0);
    add(1, 0, 9'h100, 9'h100, 9'h000, 4'd9, 1);
    add(5, 0, 9'h000, 9'h100, 9'h000, 4'd9, 0);
    add(2, 0, 9'h000, 9'h000, 9'h000, 4'd9, 0);
    // long holds: B1 (repeat-eligible), B7 (masked)
    hold_seq(0, 4'd9);
    hold_seq(6, 4'd1);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      btn_raw = tv[i].raw;
      sb.push_back(tv[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL row %0d: scoreboard empty, got 0 want 1 entry", i);
      end else begin
        e = sb.pop_front();
        check(i, e);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
